// File: rtl/mini_src_pkg.sv
// Shared constants for the Mini SRC control sequencer: opcodes, ALU codes,
// step encoding, instruction classes and the control-word layout.
package mini_src_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Address and PC arithmetic reuse the add operation of the ALU.
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_e;

  localparam int NUM_CLS   = 15;
  localparam int CL_LOAD   = 0;
  localparam int CL_LOADI  = 1;
  localparam int CL_STORE  = 2;
  localparam int CL_RALU   = 3;
  localparam int CL_IALU   = 4;
  localparam int CL_UNARY  = 5;
  localparam int CL_MULDIV = 6;
  localparam int CL_BR     = 7;
  localparam int CL_JR     = 8;
  localparam int CL_IN     = 9;
  localparam int CL_OUT    = 10;
  localparam int CL_MFHI   = 11;
  localparam int CL_MFLO   = 12;
  localparam int CL_HALT   = 13;
  localparam int CL_NOP    = 14;

  typedef logic [NUM_CLS-1:0] iclass_t;

  typedef struct packed {
    logic [4:0] alu;
    logic pout, mdr_out, zlo_out, zhi_out, hi_out, lo_out, c_out, inport_out;
    logic p_en, mar_en, mdr_en, ir_en, y_en, z_en, hi_en, lo_en, outport_en;
    logic read, write;
    logic gra, grb, grc, r_in, r_out, ba_out, con_in;
    logic inc_pc, run;
  } ctrl_t;

  // Final execute step of each class; reaching it returns the sequencer to T0.
  function automatic state_e last_step(input iclass_t c);
    if (c[CL_LOAD] || c[CL_STORE])                    return ST_T7;
    else if (c[CL_MULDIV] || c[CL_BR])                return ST_T6;
    else if (c[CL_LOADI] || c[CL_RALU] || c[CL_IALU]) return ST_T5;
    else if (c[CL_UNARY])                             return ST_T4;
    else                                              return ST_T3;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the Mini SRC sequencer (master) and the DataPath (slave).
interface control_unit_if;
  logic [31:0] ir;
  logic        con_ff;
  logic [4:0]  alu_control;
  logic Pout, MDROut, ZLOout, ZHIout, HIout, LOout, Cout, InPortout;
  logic Pen, MARen, MDRen, IRen, Yen, Zen, HIen, LOen, OutPorten;
  logic Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, ConIn;
  logic IncPC, Run;

  modport master (
    input  ir, con_ff,
    output alu_control,
    output Pout, MDROut, ZLOout, ZHIout, HIout, LOout, Cout, InPortout,
    output Pen, MARen, MDRen, IRen, Yen, Zen, HIen, LOen, OutPorten,
    output Read, Write,
    output Gra, Grb, Grc, Rin, Rout, BAout, ConIn,
    output IncPC, Run
  );

  modport slave (
    output ir, con_ff,
    input  alu_control,
    input  Pout, MDROut, ZLOout, ZHIout, HIout, LOout, Cout, InPortout,
    input  Pen, MARen, MDRen, IRen, Yen, Zen, HIen, LOen, OutPorten,
    input  Read, Write,
    input  Gra, Grb, Grc, Rin, Rout, BAout, ConIn,
    input  IncPC, Run
  );
endinterface

// File: rtl/control_unit_opcode_decode.sv
// Maps the 5-bit opcode to a one-hot instruction-class vector;
// anything not recognised decodes as NOP.
module opcode_decode
  import mini_src_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_t    class_o
);

  always_comb begin
    class_o = '0;
    case (opcode_i)
      OP_LD:   class_o[CL_LOAD]  = 1'b1;
      OP_LDI:  class_o[CL_LOADI] = 1'b1;
      OP_ST:   class_o[CL_STORE] = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
               class_o[CL_RALU]  = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:
               class_o[CL_IALU]  = 1'b1;
      OP_NEG, OP_NOT:
               class_o[CL_UNARY] = 1'b1;
      OP_MUL, OP_DIV:
               class_o[CL_MULDIV] = 1'b1;
      OP_BR:   class_o[CL_BR]    = 1'b1;
      OP_JR:   class_o[CL_JR]    = 1'b1;
      OP_IN:   class_o[CL_IN]    = 1'b1;
      OP_OUT:  class_o[CL_OUT]   = 1'b1;
      OP_MFHI: class_o[CL_MFHI]  = 1'b1;
      OP_MFLO: class_o[CL_MFLO]  = 1'b1;
      OP_HALT: class_o[CL_HALT]  = 1'b1;
      default: class_o[CL_NOP]   = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for Mini SRC: fetch in T0-T2, class-specific execute
// in T3-T7, outputs decoded from the current step and the instruction register.
module control_unit
  import mini_src_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  control_unit_if.master bus
);

  state_e  state_q, state_d;
  iclass_t cls;
  ctrl_t   ctrl;
  logic [4:0] opcode;

  assign opcode = bus.ir[31:27];

  opcode_decode u_decode (
    .opcode_i (opcode),
    .class_o  (cls)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = ST_T2;
      ST_T2:    state_d = ST_T3;
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (state_q == ST_T3 && cls[CL_HALT]) state_d = ST_HALT;
        else if (state_q == last_step(cls))   state_d = ST_T0;
        else                                  state_d = state_e'(state_q + 4'd1);
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  always_comb begin
    ctrl     = '0;
    ctrl.run = (state_q >= ST_T0) && (state_q <= ST_T7);
    case (state_q)
      ST_T0: begin
        ctrl.pout = 1'b1; ctrl.mar_en = 1'b1; ctrl.inc_pc = 1'b1;
        ctrl.z_en = 1'b1; ctrl.alu = ALU_ADD;
      end
      ST_T1: begin
        ctrl.zlo_out = 1'b1; ctrl.p_en = 1'b1; ctrl.read = 1'b1; ctrl.mdr_en = 1'b1;
      end
      ST_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_en = 1'b1;
      end
      ST_T3: begin
        // Memory classes form the effective address from base register + constant.
        if (cls[CL_LOAD] || cls[CL_LOADI] || cls[CL_STORE]) begin
          ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_en = 1'b1;
        end
        if (cls[CL_RALU] || cls[CL_IALU]) begin
          ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_en = 1'b1;
        end
        if (cls[CL_UNARY]) begin
          ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_en = 1'b1; ctrl.alu = opcode;
        end
        if (cls[CL_MULDIV]) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_en = 1'b1;
        end
        if (cls[CL_BR]) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1;
        end
        if (cls[CL_JR]) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.p_en = 1'b1;
        end
        if (cls[CL_IN]) begin
          ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end
        if (cls[CL_OUT]) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_en = 1'b1;
        end
        if (cls[CL_MFHI]) begin
          ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end
        if (cls[CL_MFLO]) begin
          ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end
      end
      ST_T4: begin
        if (cls[CL_LOAD] || cls[CL_LOADI] || cls[CL_STORE]) begin
          ctrl.c_out = 1'b1; ctrl.z_en = 1'b1; ctrl.alu = ALU_ADD;
        end
        if (cls[CL_RALU]) begin
          ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_en = 1'b1; ctrl.alu = opcode;
        end
        if (cls[CL_IALU]) begin
          ctrl.c_out = 1'b1; ctrl.z_en = 1'b1; ctrl.alu = opcode;
        end
        if (cls[CL_UNARY]) begin
          ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end
        if (cls[CL_MULDIV]) begin
          ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_en = 1'b1; ctrl.alu = opcode;
        end
        if (cls[CL_BR]) begin
          ctrl.pout = 1'b1; ctrl.y_en = 1'b1;
        end
      end
      ST_T5: begin
        if (cls[CL_LOAD] || cls[CL_STORE]) begin
          ctrl.zlo_out = 1'b1; ctrl.mar_en = 1'b1;
        end
        if (cls[CL_LOADI] || cls[CL_RALU] || cls[CL_IALU]) begin
          ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end
        if (cls[CL_MULDIV]) begin
          ctrl.zlo_out = 1'b1; ctrl.lo_en = 1'b1;
        end
        if (cls[CL_BR]) begin
          ctrl.c_out = 1'b1; ctrl.z_en = 1'b1; ctrl.alu = ALU_ADD;
        end
      end
      ST_T6: begin
        if (cls[CL_LOAD]) begin
          ctrl.read = 1'b1; ctrl.mdr_en = 1'b1;
        end
        // Store loads MDR from the register bus, so Read must stay low here.
        if (cls[CL_STORE]) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_en = 1'b1;
        end
        if (cls[CL_MULDIV]) begin
          ctrl.zhi_out = 1'b1; ctrl.hi_en = 1'b1;
        end
        if (cls[CL_BR] && bus.con_ff) begin
          ctrl.zlo_out = 1'b1; ctrl.p_en = 1'b1;
        end
      end
      ST_T7: begin
        if (cls[CL_LOAD]) begin
          ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end
        if (cls[CL_STORE]) ctrl.write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alu_control = ctrl.alu;
  assign bus.Pout        = ctrl.pout;
  assign bus.MDROut      = ctrl.mdr_out;
  assign bus.ZLOout      = ctrl.zlo_out;
  assign bus.ZHIout      = ctrl.zhi_out;
  assign bus.HIout       = ctrl.hi_out;
  assign bus.LOout       = ctrl.lo_out;
  assign bus.Cout        = ctrl.c_out;
  assign bus.InPortout   = ctrl.inport_out;
  assign bus.Pen         = ctrl.p_en;
  assign bus.MARen       = ctrl.mar_en;
  assign bus.MDRen       = ctrl.mdr_en;
  assign bus.IRen        = ctrl.ir_en;
  assign bus.Yen         = ctrl.y_en;
  assign bus.Zen         = ctrl.z_en;
  assign bus.HIen        = ctrl.hi_en;
  assign bus.LOen        = ctrl.lo_en;
  assign bus.OutPorten   = ctrl.outport_en;
  assign bus.Read        = ctrl.read;
  assign bus.Write       = ctrl.write;
  assign bus.Gra         = ctrl.gra;
  assign bus.Grb         = ctrl.grb;
  assign bus.Grc         = ctrl.grc;
  assign bus.Rin         = ctrl.r_in;
  assign bus.Rout        = ctrl.r_out;
  assign bus.BAout       = ctrl.ba_out;
  assign bus.ConIn       = ctrl.con_in;
  assign bus.IncPC       = ctrl.inc_pc;
  assign bus.Run         = ctrl.run;

`ifndef SYNTHESIS
  logic [9:0] bus_drv;
  assign bus_drv = {ctrl.pout, ctrl.mdr_out, ctrl.zlo_out, ctrl.zhi_out, ctrl.hi_out,
                    ctrl.lo_out, ctrl.c_out, ctrl.inport_out, ctrl.r_out, ctrl.ba_out};

  a_single_bus_driver: assert property (@(posedge clk) disable iff (!clr) $onehot0(bus_drv));
  a_no_read_write:     assert property (@(posedge clk) disable iff (!clr) !(ctrl.read && ctrl.write));
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for the Mini SRC control sequencer: directed vector table,
// randomized instruction stream against a step-list model, halt and async-clear corners.
module tb_control_unit;

  typedef logic [32:0] cw_t;

  localparam cw_t C_POUT  = 33'd1 << 0;
  localparam cw_t C_MDRO  = 33'd1 << 1;
  localparam cw_t C_ZLO   = 33'd1 << 2;
  localparam cw_t C_ZHI   = 33'd1 << 3;
  localparam cw_t C_HIO   = 33'd1 << 4;
  localparam cw_t C_LOO   = 33'd1 << 5;
  localparam cw_t C_COUT  = 33'd1 << 6;
  localparam cw_t C_INPO  = 33'd1 << 7;
  localparam cw_t C_PEN   = 33'd1 << 8;
  localparam cw_t C_MARE  = 33'd1 << 9;
  localparam cw_t C_MDRE  = 33'd1 << 10;
  localparam cw_t C_IRE   = 33'd1 << 11;
  localparam cw_t C_YEN   = 33'd1 << 12;
  localparam cw_t C_ZEN   = 33'd1 << 13;
  localparam cw_t C_HIE   = 33'd1 << 14;
  localparam cw_t C_LOE   = 33'd1 << 15;
  localparam cw_t C_OUTE  = 33'd1 << 16;
  localparam cw_t C_READ  = 33'd1 << 17;
  localparam cw_t C_WRITE = 33'd1 << 18;
  localparam cw_t C_GRA   = 33'd1 << 19;
  localparam cw_t C_GRB   = 33'd1 << 20;
  localparam cw_t C_GRC   = 33'd1 << 21;
  localparam cw_t C_RIN   = 33'd1 << 22;
  localparam cw_t C_ROUT  = 33'd1 << 23;
  localparam cw_t C_BAO   = 33'd1 << 24;
  localparam cw_t C_CONIN = 33'd1 << 25;
  localparam cw_t C_INCPC = 33'd1 << 26;
  localparam cw_t C_RUN   = 33'd1 << 27;

  typedef struct {
    logic [31:0] ir;
    logic        con;
    int          len;
    cw_t         e3, e4, e5, e6, e7;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  cw_t  exp_q[$];
  vec_t vec_q[$];
  cw_t  obs_w;

  control_unit_if bus();

  control_unit u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign obs_w = {bus.alu_control, bus.Run, bus.IncPC, bus.ConIn, bus.BAout, bus.Rout,
                  bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.Write, bus.Read, bus.OutPorten,
                  bus.LOen, bus.HIen, bus.Zen, bus.Yen, bus.IRen, bus.MDRen, bus.MARen,
                  bus.Pen, bus.InPortout, bus.Cout, bus.LOout, bus.HIout, bus.ZHIout,
                  bus.ZLOout, bus.MDROut, bus.Pout};

  function automatic cw_t alu_w(input logic [4:0] a);
    return {a, 28'd0};
  endfunction

  function automatic cw_t fetch_w(input int i);
    case (i)
      0:       return C_RUN | C_POUT | C_MARE | C_INCPC | C_ZEN | alu_w(5'd3);
      1:       return C_RUN | C_ZLO | C_PEN | C_READ | C_MDRE;
      default: return C_RUN | C_MDRO | C_IRE;
    endcase
  endfunction

  function automatic void s(input cw_t w);
    exp_q.push_back(w | C_RUN);
  endfunction

  // Reference: per-opcode list of control words for the whole instruction.
  function automatic void model(input logic [4:0] op, input logic con);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(fetch_w(i));
    case (op) inside
      5'd0: begin
        s(C_GRB | C_BAO | C_YEN); s(C_COUT | C_ZEN | alu_w(5'd3));
        s(C_ZLO | C_MARE); s(C_READ | C_MDRE); s(C_MDRO | C_GRA | C_RIN);
      end
      5'd1: begin
        s(C_GRB | C_BAO | C_YEN); s(C_COUT | C_ZEN | alu_w(5'd3)); s(C_ZLO | C_GRA | C_RIN);
      end
      5'd2: begin
        s(C_GRB | C_BAO | C_YEN); s(C_COUT | C_ZEN | alu_w(5'd3));
        s(C_ZLO | C_MARE); s(C_GRA | C_ROUT | C_MDRE); s(C_WRITE);
      end
      [5'd3:5'd11]: begin
        s(C_GRB | C_ROUT | C_YEN); s(C_GRC | C_ROUT | C_ZEN | alu_w(op)); s(C_ZLO | C_GRA | C_RIN);
      end
      [5'd12:5'd14]: begin
        s(C_GRB | C_ROUT | C_YEN); s(C_COUT | C_ZEN | alu_w(op)); s(C_ZLO | C_GRA | C_RIN);
      end
      5'd15, 5'd16: begin
        s(C_GRA | C_ROUT | C_YEN); s(C_GRB | C_ROUT | C_ZEN | alu_w(op));
        s(C_ZLO | C_LOE); s(C_ZHI | C_HIE);
      end
      5'd17, 5'd18: begin
        s(C_GRB | C_ROUT | C_ZEN | alu_w(op)); s(C_ZLO | C_GRA | C_RIN);
      end
      5'd19: begin
        s(C_GRA | C_ROUT | C_CONIN); s(C_POUT | C_YEN); s(C_COUT | C_ZEN | alu_w(5'd3));
        s(con ? (C_ZLO | C_PEN) : 33'd0);
      end
      5'd20:   s(C_GRA | C_ROUT | C_PEN);
      5'd22:   s(C_INPO | C_GRA | C_RIN);
      5'd23:   s(C_GRA | C_ROUT | C_OUTE);
      5'd24:   s(C_HIO | C_GRA | C_RIN);
      5'd25:   s(C_LOO | C_GRA | C_RIN);
      default: s(33'd0);
    endcase
  endfunction

  task automatic check(input string nm, input cw_t e);
    n_cmp++;
    if (obs_w !== e) begin
      n_bad++;
      $display("FAIL %s: got %09h required %09h", nm, obs_w, e);
    end
  endtask

  task automatic step_check(input string nm, input cw_t e);
    check(nm, e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [31:0] ir_v, input logic con_v);
    bus.ir     = ir_v;
    bus.con_ff = con_v;
    model(ir_v[31:27], con_v);
    $display("instr ir=%08h con_ff=%0b steps=%0d", ir_v, con_v, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      step_check($sformatf("rand_op%0d_step%0d", ir_v[31:27], i), exp_q[i]);
  endtask

  function automatic cw_t vec_exp(input vec_t v, input int st);
    case (st)
      0, 1, 2: return fetch_w(st);
      3:       return v.e3 | C_RUN;
      4:       return v.e4 | C_RUN;
      5:       return v.e5 | C_RUN;
      6:       return v.e6 | C_RUN;
      default: return v.e7 | C_RUN;
    endcase
  endfunction

  task automatic add_vec(input logic [31:0] ir_v, input logic con_v, input int len,
                         input cw_t e3, input cw_t e4, input cw_t e5, input cw_t e6, input cw_t e7);
    vec_t v;
    v.ir = ir_v; v.con = con_v; v.len = len;
    v.e3 = e3; v.e4 = e4; v.e5 = e5; v.e6 = e6; v.e7 = e7;
    vec_q.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    bus.ir     = 32'd0;
    bus.con_ff = 1'b0;

    add_vec(32'h00800075, 1'b0, 8, C_GRB | C_BAO | C_YEN, C_COUT | C_ZEN | alu_w(5'd3),
            C_ZLO | C_MARE, C_READ | C_MDRE, C_MDRO | C_GRA | C_RIN);
    add_vec(32'h19A28000, 1'b0, 6, C_GRB | C_ROUT | C_YEN, C_GRC | C_ROUT | C_ZEN | alu_w(5'd3),
            C_ZLO | C_GRA | C_RIN, 0, 0);
    add_vec(32'h10800087, 1'b0, 8, C_GRB | C_BAO | C_YEN, C_COUT | C_ZEN | alu_w(5'd3),
            C_ZLO | C_MARE, C_GRA | C_ROUT | C_MDRE, C_WRITE);
    add_vec(32'h81880000, 1'b0, 7, C_GRA | C_ROUT | C_YEN, C_GRB | C_ROUT | C_ZEN | alu_w(5'd16),
            C_ZLO | C_LOE, C_ZHI | C_HIE, 0);
    add_vec(32'h9800000A, 1'b1, 7, C_GRA | C_ROUT | C_CONIN, C_POUT | C_YEN,
            C_COUT | C_ZEN | alu_w(5'd3), C_ZLO | C_PEN, 0);
    add_vec(32'h9800000A, 1'b0, 7, C_GRA | C_ROUT | C_CONIN, C_POUT | C_YEN,
            C_COUT | C_ZEN | alu_w(5'd3), 0, 0);
    add_vec(32'h08000000, 1'b0, 6, C_GRB | C_BAO | C_YEN, C_COUT | C_ZEN | alu_w(5'd3),
            C_ZLO | C_GRA | C_RIN, 0, 0);
    add_vec(32'h68000000, 1'b0, 6, C_GRB | C_ROUT | C_YEN, C_COUT | C_ZEN | alu_w(5'd13),
            C_ZLO | C_GRA | C_RIN, 0, 0);
    add_vec(32'h88800000, 1'b0, 5, C_GRB | C_ROUT | C_ZEN | alu_w(5'd17), C_ZLO | C_GRA | C_RIN, 0, 0, 0);
    add_vec(32'hA0000000, 1'b0, 4, C_GRA | C_ROUT | C_PEN, 0, 0, 0, 0);
    add_vec(32'hB0000000, 1'b0, 4, C_INPO | C_GRA | C_RIN, 0, 0, 0, 0);
    add_vec(32'hB8000000, 1'b0, 4, C_GRA | C_ROUT | C_OUTE, 0, 0, 0, 0);
    add_vec(32'hC0000000, 1'b0, 4, C_HIO | C_GRA | C_RIN, 0, 0, 0, 0);
    add_vec(32'hC8000000, 1'b0, 4, C_LOO | C_GRA | C_RIN, 0, 0, 0, 0);
    add_vec(32'hD0000000, 1'b0, 4, 0, 0, 0, 0, 0);
    add_vec(32'hF8000000, 1'b0, 4, 0, 0, 0, 0, 0);

    // Reset held for two cycles, then released away from the clock edge.
    @(negedge clk); check("reset_cycle0", 33'd0);
    @(negedge clk); check("reset_cycle1", 33'd0);
    clr = 1'b1;
    #1 check("reset_released_before_edge", 33'd0);
    @(posedge clk);
    @(negedge clk);

    foreach (vec_q[k]) begin
      bus.ir     = vec_q[k].ir;
      bus.con_ff = vec_q[k].con;
      $display("vector %0d ir=%08h con_ff=%0b steps=%0d", k, vec_q[k].ir, vec_q[k].con, vec_q[k].len);
      for (int st = 0; st < vec_q[k].len; st++)
        step_check($sformatf("vec%0d_T%0d", k, st), vec_exp(vec_q[k], st));
    end

    for (int k = 0; k < 150; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)));
    end

    // Halt: Run drops after T3 and stays down while inputs wiggle.
    run_instr(32'hD8000000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.ir     = $urandom;
      bus.con_ff = 1'($urandom_range(0, 1));
      step_check($sformatf("halt_hold%0d", i), 33'd0);
    end

    clr = 1'b0;
    #1 check("halt_clr_async", 33'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Clear asserted in the middle of T5 of a load.
    bus.ir     = 32'h00800075;
    bus.con_ff = 1'b0;
    model(5'd0, 1'b0);
    $display("instr ir=%08h aborted in T5 by clr", bus.ir);
    for (int i = 0; i < 5; i++) step_check($sformatf("abort_ld_T%0d", i), exp_q[i]);
    check("abort_ld_T5", exp_q[5]);
    #2 clr = 1'b0;
    #1 check("mid_T5_clr_async", 33'd0);
    @(posedge clk);
    @(negedge clk);
    check("clr_held_over_edge", 33'd0);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("clr_release_T0", fetch_w(0));
    run_instr(32'h00800075, 1'b0);
    check("after_ld_back_to_T0", fetch_w(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
